distributor4: RTL and testbench

//   1-to-4 data distributor. This is the inverse of the 4-input selector: one input

---
 rtl/distributor4_if.sv | 25 ++
 rtl/distributor4.sv | 84 ++++++++
 tb/tb_distributor4.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/distributor4_if.sv
// rtl/distributor4_if.sv - producer/consumer bundle for the 1-to-4 distributor
interface distributor4_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_select;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;

    modport master (
        output in_data, in_select, in_valid, out_ready,
        input  in_ready, out_data0, out_data1, out_data2, out_data3, out_valid
    );

    modport slave (
        input  in_data, in_select, in_valid, out_ready,
        output in_ready, out_data0, out_data1, out_data2, out_data3, out_valid
    );
endinterface

// File: rtl/distributor4.sv
// rtl/distributor4.sv - 1-to-4 stream distributor with a fall-through FIFO per port
module distributor4 #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input logic           clk_i,
    input logic           rst_n_i,
    distributor4_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [4][DEPTH];
    logic [WIDTH-1:0] mem_d [4][DEPTH];
    logic [PW-1:0]    wr_ptr_q [4];
    logic [PW-1:0]    wr_ptr_d [4];
    logic [PW-1:0]    rd_ptr_q [4];
    logic [PW-1:0]    rd_ptr_d [4];
    logic [CW-1:0]    count_q [4];
    logic [CW-1:0]    count_d [4];

    logic             in_ready;
    logic [3:0]       valid;
    logic [3:0]       push;
    logic [3:0]       pop;
    logic [WIDTH-1:0] head [4];

    // Ready depends only on registered counts, so consumer stalls never reach the producer combinationally.
    always_comb begin
        in_ready = (count_q[bus.in_select] != FULL);
        valid    = '0;
        push     = '0;
        pop      = '0;
        for (int n = 0; n < 4; n++) begin
            valid[n] = (count_q[n] != '0);
            push[n]  = bus.in_valid & in_ready & (bus.in_select == 2'(n));
            pop[n]   = valid[n] & bus.out_ready[n];
            head[n]  = valid[n] ? mem_q[n][rd_ptr_q[n]] : '0;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int n = 0; n < 4; n++) begin
            if (push[n]) begin
                mem_d[n][wr_ptr_q[n]] = bus.in_data;
                wr_ptr_d[n]           = wr_ptr_q[n] + PW'(1);
            end
            if (pop[n]) begin
                rd_ptr_d[n] = rd_ptr_q[n] + PW'(1);
            end
            count_d[n] = count_q[n] + CW'(push[n]) - CW'(pop[n]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int n = 0; n < 4; n++) begin
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
                count_q[n]  <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[n][e] <= '0;
                end
            end
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid;
    assign bus.out_data0 = head[0];
    assign bus.out_data1 = head[1];
    assign bus.out_data2 = head[2];
    assign bus.out_data3 = head[3];
endmodule

// File: tb/tb_distributor4.sv
// tb/tb_distributor4.sv - directed self-checking bench for distributor4
module tb_distributor4;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    distributor4_if #(.WIDTH(4)) bus ();

    distributor4 #(.WIDTH(4), .DEPTH(2)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_data   = 4'h0;
        bus.in_select = 2'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b want 0000", bus.out_valid); end
        checks++; if ({bus.out_data0, bus.out_data1, bus.out_data2, bus.out_data3} !== 16'h0) begin errors++;
            $display("FAIL reset_data got %h want 0000", {bus.out_data0, bus.out_data1, bus.out_data2, bus.out_data3}); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.in_ready); end
        step();
        rst_n = 1'b1;
        repeat (5) step();
        checks++; if (bus.out_valid !== 4'b0000 || bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL idle_after_reset got valid=%b ready=%b want 0000/1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_single_push();
        bus.in_data = 4'hA; bus.in_select = 2'd2; bus.in_valid = 1'b1; bus.out_ready = 4'b0000;
        step();
        bus.in_valid = 1'b0; bus.in_data = 4'hx;
        #1;
        checks++; if (bus.out_valid !== 4'b0100) begin errors++; $display("FAIL single_valid got %b want 0100", bus.out_valid); end
        checks++; if (bus.out_data2 !== 4'hA) begin errors++; $display("FAIL single_data2 got %h want a", bus.out_data2); end
        checks++; if ({bus.out_data0, bus.out_data1, bus.out_data3} !== 12'h0) begin errors++;
            $display("FAIL single_others got %h want 000", {bus.out_data0, bus.out_data1, bus.out_data3}); end
        bus.out_ready = 4'b0100;
        step();
        bus.out_ready = 4'b0000;
        checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL single_drain got %b want 0000", bus.out_valid); end
    endtask

    task automatic test_full_port();
        bus.in_select = 2'd1; bus.in_valid = 1'b1; bus.out_ready = 4'b0000;
        bus.in_data = 4'h3; step();
        bus.in_data = 4'h5; step();
        bus.in_data = 4'h7; #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", bus.in_ready); end
        step();
        bus.in_valid = 1'b0; bus.in_select = 2'd0; #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL other_port_ready got %b want 1", bus.in_ready); end
        bus.out_ready = 4'b0010; #1;
        checks++; if (bus.out_data1 !== 4'h3) begin errors++; $display("FAIL full_first got %h want 3", bus.out_data1); end
        step();
        checks++; if (bus.out_data1 !== 4'h5 || bus.out_valid[1] !== 1'b1) begin errors++;
            $display("FAIL full_second got %h valid=%b want 5/1", bus.out_data1, bus.out_valid[1]); end
        step();
        checks++; if (bus.out_valid[1] !== 1'b0) begin errors++; $display("FAIL full_empty got %b want 0 (7 must not be stored)", bus.out_valid[1]); end
        bus.out_ready = 4'b0000;
    endtask

    task automatic test_wrap();
        bus.in_select = 2'd3; bus.in_valid = 1'b1; bus.out_ready = 4'b0000;
        bus.in_data = 4'h8; step();
        bus.in_data = 4'h9; step();
        bus.in_data = 4'hC; bus.out_ready = 4'b1000; #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL wrap_full_ready got %b want 0", bus.in_ready); end
        step();
        bus.out_ready = 4'b0000; #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_data3 !== 4'h9) begin errors++;
            $display("FAIL wrap_after_pop got ready=%b data=%h want 1/9", bus.in_ready, bus.out_data3); end
        step();
        bus.in_valid = 1'b0; bus.out_ready = 4'b1000; #1;
        checks++; if (bus.out_data3 !== 4'h9) begin errors++; $display("FAIL wrap_head9 got %h want 9", bus.out_data3); end
        step();
        checks++; if (bus.out_data3 !== 4'hC) begin errors++; $display("FAIL wrap_headC got %h want c", bus.out_data3); end
        step();
        checks++; if (bus.out_valid[3] !== 1'b0) begin errors++; $display("FAIL wrap_drained got %b want 0", bus.out_valid[3]); end
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 4'(i); #1;
            if (i > 0) begin
                checks++; if (bus.out_data3 !== 4'(i - 1) || bus.in_ready !== 1'b1) begin errors++;
                    $display("FAIL wrap_order[%0d] got data=%h ready=%b want %h/1", i, bus.out_data3, bus.in_ready, 4'(i - 1)); end
            end
            step();
        end
        bus.in_valid = 1'b0; #1;
        checks++; if (bus.out_data3 !== 4'h7) begin errors++; $display("FAIL wrap_last got %h want 7", bus.out_data3); end
        step();
        bus.out_ready = 4'b0000;
        checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL wrap_end_empty got %b want 0000", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got;
        bus.out_ready = 4'b1111; bus.in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus.in_select = 2'(c); bus.in_data = 4'(c + 1); #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", c, bus.in_ready); end
            step();
            case (c)
                0: got = bus.out_data0;
                1: got = bus.out_data1;
                2: got = bus.out_data2;
                default: got = bus.out_data3;
            endcase
            checks++; if (bus.out_valid !== 4'(1 << c) || got !== 4'(c + 1)) begin errors++;
                $display("FAIL b2b_pulse[%0d] got valid=%b data=%h want %b/%h", c, bus.out_valid, got, 4'(1 << c), 4'(c + 1)); end
        end
        bus.in_valid = 1'b0;
        step();
        checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL b2b_end got %b want 0000", bus.out_valid); end
        bus.out_ready = 4'b0000;
    endtask

    task automatic test_async_reset();
        bus.in_valid = 1'b1; bus.out_ready = 4'b0000;
        bus.in_select = 2'd0; bus.in_data = 4'h6; step();
        bus.in_data = 4'hE; step();
        bus.in_select = 2'd2; bus.in_data = 4'hD; step();
        bus.in_valid = 1'b0; #1;
        checks++; if (bus.out_valid !== 4'b0101) begin errors++; $display("FAIL areset_pre got %b want 0101", bus.out_valid); end
        rst_n = 1'b0; #1;
        checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL areset_valid got %b want 0000", bus.out_valid); end
        checks++; if ({bus.out_data0, bus.out_data2} !== 8'h0 || bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL areset_data got %h ready=%b want 00/1", {bus.out_data0, bus.out_data2}, bus.in_ready); end
        #1 rst_n = 1'b1;
        step();
        checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL areset_after got %b want 0000", bus.out_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_single_push();
        test_full_port();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
